// File: rtl/clint_rtc_gen.sv
// Fractional-rate RTC square-wave generator feeding the CLINT rtc_i input.
// Each half-period lasts max(int,1) cycles plus one extra cycle whenever the fraction accumulator overflows.
module clint_rtc_gen #(
  parameter int unsigned           CntWidth      = 32,
  parameter int unsigned           FracWidth     = 16,
  parameter logic [CntWidth-1:0]   ResetHalfInt  = CntWidth'(15258),
  parameter logic [FracWidth-1:0]  ResetHalfFrac = FracWidth'(16'hC9FD)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CntWidth-1:0]  cfg_half_int_i,
  input  logic [FracWidth-1:0] cfg_half_frac_i,
  output logic                 rtc_o,
  output logic                 tick_o,
  output logic                 active_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CntWidth-1:0]  r_cnt;
  logic [FracWidth-1:0] r_acc;
  logic                 r_rtc;
  logic                 r_tick;
  logic [CntWidth-1:0]  r_act_int;
  logic [FracWidth-1:0] r_act_frac;
  logic [CntWidth-1:0]  r_sh_int;
  logic [FracWidth-1:0] r_sh_frac;
  logic                 r_sh_valid;

  logic                 w_reload;
  logic                 w_clear;
  logic                 w_toggle;
  logic                 w_dec;
  logic                 w_cnt_zero;
  logic                 w_xfer;
  logic                 w_direct;
  logic                 w_apply_sh;
  logic [CntWidth-1:0]  w_sel_int;
  logic [FracWidth-1:0] w_sel_frac;
  logic [CntWidth-1:0]  w_int_eff;
  logic [FracWidth:0]   w_sum;
  logic [CntWidth:0]    w_half;
  logic [CntWidth-1:0]  w_load;

  // Counter reload value is H-1, clamped so a wide H can never wrap the counter.
  function automatic logic [CntWidth-1:0] sat_dec(input logic [CntWidth:0] h);
    logic [CntWidth:0] d;
    d = h - 1'b1;
    if (d[CntWidth]) return '1;
    else             return d[CntWidth-1:0];
  endfunction

  assign w_cnt_zero = (r_cnt == '0);
  assign w_xfer     = cfg_valid_i & ~r_sh_valid;

  // A pending shadow is what the reload at this boundary must use.
  assign w_sel_int  = r_sh_valid ? r_sh_int  : r_act_int;
  assign w_sel_frac = r_sh_valid ? r_sh_frac : r_act_frac;
  assign w_int_eff  = (w_sel_int == '0) ? CntWidth'(1) : w_sel_int;
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_sel_frac};
  assign w_half     = {1'b0, w_int_eff} + (CntWidth+1)'(w_sum[FracWidth]);
  assign w_load     = sat_dec(w_half);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_reload    = 1'b0;
    w_clear     = 1'b0;
    w_toggle    = 1'b0;
    w_dec       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (en_i) begin
          w_state_nxt = S_RUN;
          w_reload    = 1'b1;
        end
      end
      S_RUN, S_STOP: begin
        if (!en_i && !r_rtc) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end else if (!en_i) begin
          // High phase finishes naturally so no truncated pulse reaches the CLINT.
          if (w_cnt_zero) begin
            w_state_nxt = S_IDLE;
            w_clear     = 1'b1;
            w_toggle    = 1'b1;
          end else begin
            w_state_nxt = S_STOP;
            w_dec       = 1'b1;
          end
        end else begin
          w_state_nxt = S_RUN;
          if (w_cnt_zero) begin
            w_toggle = 1'b1;
            w_reload = 1'b1;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    active_o    = (r_state != S_IDLE);
    cfg_ready_o = ~r_sh_valid;
    rtc_o       = r_rtc;
    tick_o      = r_tick;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_rtc  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      if (w_reload) begin
        r_cnt <= w_load;
        r_acc <= w_sum[FracWidth-1:0];
      end else if (w_clear) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (w_dec) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_toggle) r_rtc <= ~r_rtc;
      r_tick <= w_toggle & ~r_rtc;
    end
  end

  // Idle (or entering idle) writes config straight to active; otherwise it waits in the shadow.
  assign w_direct   = w_xfer & ((r_state == S_IDLE) | w_clear);
  assign w_apply_sh = r_sh_valid & (w_reload | w_clear);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_act_int  <= ResetHalfInt;
      r_act_frac <= ResetHalfFrac;
      r_sh_int   <= '0;
      r_sh_frac  <= '0;
      r_sh_valid <= 1'b0;
    end else begin
      if (w_apply_sh) begin
        r_act_int  <= r_sh_int;
        r_act_frac <= r_sh_frac;
        r_sh_valid <= 1'b0;
      end
      if (w_direct) begin
        r_act_int  <= cfg_half_int_i;
        r_act_frac <= cfg_half_frac_i;
      end else if (w_xfer) begin
        r_sh_int   <= cfg_half_int_i;
        r_sh_frac  <= cfg_half_frac_i;
        r_sh_valid <= 1'b1;
      end
    end
  end

endmodule
